timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// Shared prescaled timer, handed out round-robin to NUM_REQ requesters.
// The owner holds its grant for duration*DIV_COUNT clk cycles, then gets a
// one-cycle done pulse; dropping its request early aborts without done.
module timer_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DIV_COUNT = 48000,
    parameter int unsigned DUR_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DUR_W-1:0] duration,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     tick,
    output logic                     busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned PSC_W = $clog2(DIV_COUNT);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV_COUNT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state, w_state_d;
    logic [NUM_REQ-1:0] r_grant, w_grant_d;
    logic [PSC_W-1:0]   r_psc, w_psc_d;
    logic [DUR_W-1:0]   r_rem, w_rem_d;
    logic [IDX_W-1:0]   r_last, w_last_d;
    logic [IDX_W-1:0]   r_win, w_win_d;

    logic [IDX_W-1:0]   w_pick;
    logic               w_tick;
    logic [DUR_W-1:0]   w_dur [NUM_REQ];

    // Split the packed duration bus into one field per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
        assign w_dur[g] = duration[g*DUR_W +: DUR_W];
    end

    // Round-robin pick: first active request at or above last_winner+1, wrapping.
    always_comb begin : arbitrate
        logic             v_found;
        logic [IDX_W-1:0] v_idx;
        int unsigned      v_cand;
        w_pick  = '0;
        v_found = 1'b0;
        v_idx   = '0;
        v_cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_cand = (32'(r_last) + 32'd1 + i) % NUM_REQ;
            v_idx  = IDX_W'(v_cand);
            if (!v_found && req[v_idx]) begin
                v_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Outputs decoded from state; done mirrors grant only in the DONE cycle.
    always_comb begin
        w_tick = (r_state == StRun) && (r_psc == PSC_MAX) && (r_rem != '0);
        tick   = w_tick;
        grant  = r_grant;
        done   = (r_state == StDone) ? r_grant : '0;
        busy   = (r_state != StIdle);
    end

    // Next-state logic: arbitration, prescaling, countdown, abort.
    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_psc_d   = r_psc;
        w_rem_d   = r_rem;
        w_last_d  = r_last;
        w_win_d   = r_win;
        unique case (r_state)
            StIdle: begin
                w_grant_d = '0;
                w_psc_d   = '0;
                if (req != '0) begin
                    w_state_d = StRun;
                    w_win_d   = w_pick;
                    w_grant_d = NUM_REQ'(1) << w_pick;
                    w_rem_d   = w_dur[w_pick];
                end
            end
            StRun: begin
                if (!req[r_win]) begin
                    // Owner withdrew: abandon silently but still rotate priority.
                    w_state_d = StIdle;
                    w_grant_d = '0;
                    w_psc_d   = '0;
                    w_last_d  = r_win;
                end else if (r_rem == '0) begin
                    w_state_d = StDone;
                end else begin
                    w_psc_d = (r_psc == PSC_MAX) ? '0 : r_psc + PSC_W'(1);
                    if (w_tick) begin
                        w_rem_d = r_rem - DUR_W'(1);
                        if (r_rem == DUR_W'(1)) begin
                            w_state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_grant_d = '0;
                w_psc_d   = '0;
                w_last_d  = r_win;
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_psc   <= '0;
            r_rem   <= '0;
            r_last  <= LAST_RST;
            r_win   <= '0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_psc   <= w_psc_d;
            r_rem   <= w_rem_d;
            r_last  <= w_last_d;
            r_win   <= w_win_d;
        end
    end

endmodule
